// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Holds the FSM state type, vote-window offsets around mid-bit and legal config limits.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  localparam int unsigned PRESC_MIN = 8;
  localparam int unsigned PRESC_MAX = 32;
  localparam int unsigned DLEN_MIN  = 5;

  // Samples are taken at mid-VOTE_PRE .. mid+VOTE_POST; the vote is usable at mid+VOTE_RDY
  localparam int unsigned VOTE_PRE  = 1;
  localparam int unsigned VOTE_POST = 1;
  localparam int unsigned VOTE_RDY  = 2;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with three-sample majority vote.
// bit_done marks the cycle the voted bit is valid; bit_end marks the last cycle of a bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               restart,
  input  logic               rx,
  input  logic [PRESC_W-1:0] presc,
  output logic               bit_done,
  output logic               bit_val,
  output logic               bit_end
);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] mid;
  logic [2:0]         smp;
  logic               in_window;

  assign mid       = presc >> 1;
  assign in_window = (edge_cnt >= mid - PRESC_W'(VOTE_PRE)) &&
                     (edge_cnt <= mid + PRESC_W'(VOTE_POST));
  assign bit_done  = run && (edge_cnt == mid + PRESC_W'(VOTE_RDY));
  assign bit_end   = run && (edge_cnt == presc - PRESC_W'(1));
  assign bit_val   = maj3(smp);

  // The start-detect cycle in IDLE is edge 0 of the start bit, so counting resumes at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      smp      <= '1;
    end else if (restart) begin
      edge_cnt <= PRESC_W'(1);
    end else if (run) begin
      edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_W'(1);
      if (in_window) smp <= {smp[1:0], rx};
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver: synchroniser, frame FSM, shift register and parity check.
// Frame format is captured on the IDLE->START transition and clamped to the legal range.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W_MAX  = 9,
  parameter int unsigned PRESC_W     = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic [3:0]            DATA_LEN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_W_MAX-1:0] P_DATA,
  output logic                  DATA_Valid,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  state_t                  state, nxt;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    rx_s;
  logic [PRESC_W-1:0]      presc_q;
  logic [3:0]              dlen_q, bit_cnt;
  logic                    par_en_q, par_typ_q, stop2_q;
  logic [DATA_W_MAX-1:0]   shreg;
  logic                    par_acc, par_err, stp_err;
  logic                    bit_done, bit_val, bit_end;
  logic                    last_stop, stp_now, run, restart;

  function automatic logic [PRESC_W-1:0] clamp_presc(input logic [PRESC_W-1:0] p);
    logic [PRESC_W-1:0] e;
    e = {p[PRESC_W-1:1], 1'b0};
    if (e < PRESC_W'(PRESC_MIN)) return PRESC_W'(PRESC_MIN);
    if (e > PRESC_W'(PRESC_MAX)) return PRESC_W'(PRESC_MAX);
    return e;
  endfunction

  function automatic logic [3:0] clamp_dlen(input logic [3:0] d);
    if (d < 4'(DLEN_MIN))   return 4'(DLEN_MIN);
    if (d > 4'(DATA_W_MAX)) return 4'(DATA_W_MAX);
    return d;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], RX_IN};
  end
  assign rx_s = sync[SYNC_STAGES-1];

  assign run     = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign restart = (state == IDLE) && !rx_s;

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk      (CLK),
    .rst      (RST),
    .run      (run),
    .restart  (restart),
    .rx       (rx_s),
    .presc    (presc_q),
    .bit_done (bit_done),
    .bit_val  (bit_val),
    .bit_end  (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    last_stop = (state == STOP) && bit_done && (bit_cnt == 4'(stop2_q));
    stp_now   = stp_err | ~bit_val;
    case (state)
      IDLE:    if (!rx_s) nxt = START;
      START:   if (bit_done && bit_val) nxt = IDLE;
               else if (bit_end)        nxt = DATA;
      DATA:    if (bit_end && (bit_cnt == dlen_q - 4'd1)) nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) nxt = STOP;
      STOP:    if (last_stop) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // bit_cnt indexes data bits in DATA and counts stop bits in STOP
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q    <= PRESC_W'(PRESC_MIN);
      dlen_q     <= 4'(DLEN_MIN);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      P_DATA     <= '0;
      DATA_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      case (state)
        IDLE: if (restart) begin
          presc_q   <= clamp_presc(Prescale);
          dlen_q    <= clamp_dlen(DATA_LEN);
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          stop2_q   <= STOP2;
          bit_cnt   <= '0;
          shreg     <= '0;
          par_acc   <= 1'b0;
          par_err   <= 1'b0;
          stp_err   <= 1'b0;
        end
        DATA: begin
          if (bit_done) begin
            shreg[bit_cnt] <= bit_val;
            par_acc        <= par_acc ^ bit_val;
          end
          if (bit_end) bit_cnt <= (nxt == DATA) ? bit_cnt + 4'd1 : '0;
        end
        PARITY: if (bit_done) par_err <= (bit_val != (par_acc ^ par_typ_q));
        STOP: begin
          if (bit_done) stp_err <= stp_now;
          if (bit_end)  bit_cnt <= bit_cnt + 4'd1;
          if (last_stop) begin
            PAR_ERR    <= par_err;
            STP_ERR    <= stp_now;
            DATA_Valid <= !par_err && !stp_now;
            if (!par_err && !stp_now) P_DATA <= shreg;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state != IDLE);

endmodule
